// File: rtl/mole_field_ctrl.sv
// Whack-a-mole field: one EMPTY/UP/WHACKED FSM per hole, LFSR-driven spawner, hit/miss scoring.
// Define MOLE_FIELD_COMBO_EN for streak tracking and double points on long streaks.
module mole_field_ctrl #(
    parameter int          NUM_HOLES   = 5,
    parameter int          LIFE_W      = 8,
    parameter int          SCORE_W     = 8,
    parameter int          MAX_ACTIVE  = 2,
    parameter int          WHACK_TICKS = 1,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic                         clear,
    input  logic                         tick,
    input  logic [LIFE_W-1:0]            mole_life,
    input  logic                         hit_valid,
    input  logic [$clog2(NUM_HOLES)-1:0] hit_idx,
    output logic [NUM_HOLES-1:0]         moles,
    output logic [NUM_HOLES-1:0]         whacked,
    output logic [SCORE_W-1:0]           score,
    output logic [SCORE_W-1:0]           miss_count,
    output logic                         hit_pulse,
    output logic                         miss_pulse,
    output logic                         escape_pulse,
    output logic [7:0]                   streak
);
    localparam int          WW        = (WHACK_TICKS < 2) ? 1 : $clog2(WHACK_TICKS + 1);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {EMPTY, UP, WHACKED} hole_e;

    hole_e              st_q   [NUM_HOLES];
    hole_e              st_d   [NUM_HOLES];
    logic [LIFE_W-1:0]  life_q [NUM_HOLES];
    logic [LIFE_W-1:0]  life_d [NUM_HOLES];
    logic [WW-1:0]      wcnt_q [NUM_HOLES];
    logic [WW-1:0]      wcnt_d [NUM_HOLES];
    logic [15:0]        lfsr_q, lfsr_d;
    logic [SCORE_W-1:0] score_q, score_d, miss_q, miss_d;
    logic [7:0]         streak_q, streak_d;
    logic [NUM_HOLES-1:0] moles_q, moles_d, whacked_q, whacked_d;
    logic               hit_q, hit_d, missp_q, missp_d, esc_q, esc_d;

    logic               hit_ok, hit_up, spawn_en;
    logic [15:0]        start;
    logic [LIFE_W-1:0]  spawn_life;
    logic [1:0]         hit_inc;
    int                 up_cnt, spawn_sel, scan_j;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [1:0] b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + (SCORE_W + 1)'(b);
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction

    always_comb begin
        lfsr_d     = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        start      = lfsr_q % 16'(NUM_HOLES);
        spawn_life = (mole_life == '0) ? LIFE_W'(1) : mole_life;
        hit_ok     = hit_valid && (int'(hit_idx) < NUM_HOLES);

        // All decisions below look only at pre-edge hole state.
        up_cnt = 0;
        hit_up = 1'b0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            if (st_q[i] == UP) begin
                up_cnt = up_cnt + 1;
                if (hit_ok && int'(hit_idx) == i) hit_up = 1'b1;
            end
        end
        spawn_en  = tick && (up_cnt < MAX_ACTIVE);
        spawn_sel = -1;
        scan_j    = 0;
        for (int k = NUM_HOLES - 1; k >= 0; k--) begin
            scan_j = (int'(start) + k) % NUM_HOLES;
            if (st_q[scan_j] == EMPTY) spawn_sel = scan_j;
        end

`ifdef MOLE_FIELD_COMBO_EN
        hit_inc  = (streak_q >= 8'd4) ? 2'd2 : 2'd1;
        streak_d = streak_q;
`else
        hit_inc  = 2'd1;
        streak_d = 8'd0;
`endif

        for (int i = 0; i < NUM_HOLES; i++) begin
            st_d[i]   = st_q[i];
            life_d[i] = life_q[i];
            wcnt_d[i] = wcnt_q[i];
        end
        score_d = score_q;
        miss_d  = miss_q;
        hit_d   = 1'b0;
        missp_d = 1'b0;
        esc_d   = 1'b0;

        if (clear) begin
            for (int i = 0; i < NUM_HOLES; i++) begin
                st_d[i]   = EMPTY;
                life_d[i] = '0;
                wcnt_d[i] = '0;
            end
            score_d  = '0;
            miss_d   = '0;
            streak_d = 8'd0;
        end else if (enable) begin
            for (int i = 0; i < NUM_HOLES; i++) begin
                if (hit_up && int'(hit_idx) == i) begin
                    st_d[i]   = WHACKED;
                    wcnt_d[i] = WW'(WHACK_TICKS);
                    life_d[i] = '0;
                end else if (tick && st_q[i] == UP) begin
                    if (life_q[i] <= LIFE_W'(1)) begin
                        st_d[i]   = EMPTY;
                        life_d[i] = '0;
                        esc_d     = 1'b1;
                    end else begin
                        life_d[i] = life_q[i] - LIFE_W'(1);
                    end
                end else if (tick && st_q[i] == WHACKED) begin
                    if (wcnt_q[i] <= WW'(1)) begin
                        st_d[i]   = EMPTY;
                        wcnt_d[i] = '0;
                    end else begin
                        wcnt_d[i] = wcnt_q[i] - WW'(1);
                    end
                end else if (spawn_en && spawn_sel == i) begin
                    st_d[i]   = UP;
                    life_d[i] = spawn_life;
                end
            end
            if (hit_up) begin
                hit_d   = 1'b1;
                score_d = sat_add(score_q, hit_inc);
            end else if (hit_ok) begin
                missp_d = 1'b1;
                miss_d  = sat_add(miss_q, 2'd1);
            end
`ifdef MOLE_FIELD_COMBO_EN
            if (missp_d || esc_d)  streak_d = 8'd0;
            else if (hit_d)        streak_d = (streak_q == 8'hFF) ? 8'hFF : streak_q + 8'd1;
`endif
        end

        for (int i = 0; i < NUM_HOLES; i++) begin
            moles_d[i]   = (st_d[i] == UP);
            whacked_d[i] = (st_d[i] == WHACKED);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_HOLES; i++) begin
                st_q[i]   <= EMPTY;
                life_q[i] <= '0;
                wcnt_q[i] <= '0;
            end
            lfsr_q    <= SEED;
            score_q   <= '0;
            miss_q    <= '0;
            streak_q  <= 8'd0;
            moles_q   <= '0;
            whacked_q <= '0;
            hit_q     <= 1'b0;
            missp_q   <= 1'b0;
            esc_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_HOLES; i++) begin
                st_q[i]   <= st_d[i];
                life_q[i] <= life_d[i];
                wcnt_q[i] <= wcnt_d[i];
            end
            lfsr_q    <= lfsr_d;
            score_q   <= score_d;
            miss_q    <= miss_d;
            streak_q  <= streak_d;
            moles_q   <= moles_d;
            whacked_q <= whacked_d;
            hit_q     <= hit_d;
            missp_q   <= missp_d;
            esc_q     <= esc_d;
        end
    end

    assign moles        = moles_q;
    assign whacked      = whacked_q;
    assign score        = score_q;
    assign miss_count   = miss_q;
    assign hit_pulse    = hit_q;
    assign miss_pulse   = missp_q;
    assign escape_pulse = esc_q;
    assign streak       = streak_q;

endmodule

// File: tb/tb_mole_field_ctrl.sv
// Randomized and directed bench for mole_field_ctrl against a rule-level reference model.
// Expectations follow MOLE_FIELD_COMBO_EN when the macro is defined for the build.
module tb_mole_field_ctrl;
    localparam int NH   = 5;
    localparam int MA   = 2;
    localparam int WT   = 1;
    localparam int SMAX = 255;

    logic       clock = 1'b0;
    logic       resetn, enable, clear, tick, hit_valid;
    logic [7:0] mole_life;
    logic [2:0] hit_idx;
    logic [4:0] moles, whacked;
    logic [7:0] score, miss_count, streak;
    logic       hit_pulse, miss_pulse, escape_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per-hole 0=empty 1=up 2=whacked, remaining life / whack ticks.
    int          st [NH];
    int          life [NH];
    int          wc [NH];
    int          m_score, m_miss, m_streak, m_hit, m_missp, m_esc;
    logic [15:0] m_lfsr;

    mole_field_ctrl dut (
        .clock(clock), .resetn(resetn), .enable(enable), .clear(clear), .tick(tick),
        .mole_life(mole_life), .hit_valid(hit_valid), .hit_idx(hit_idx),
        .moles(moles), .whacked(whacked), .score(score), .miss_count(miss_count),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .escape_pulse(escape_pulse),
        .streak(streak)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < NH; i++) begin st[i] = 0; life[i] = 0; wc[i] = 0; end
        m_score = 0; m_miss = 0; m_streak = 0;
        m_hit = 0; m_missp = 0; m_esc = 0;
        m_lfsr = 16'hACE1;
    endtask

    task automatic mstep();
        int pre [NH];
        int up, h, s;
        logic [15:0] lf;
        lf = m_lfsr;
        m_lfsr = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
        m_hit = 0; m_missp = 0; m_esc = 0;
        if (clear) begin
            for (int i = 0; i < NH; i++) begin st[i] = 0; life[i] = 0; wc[i] = 0; end
            m_score = 0; m_miss = 0; m_streak = 0;
            return;
        end
        if (!enable) return;
        pre = st;
        up = 0;
        for (int i = 0; i < NH; i++) if (pre[i] == 1) up++;
        h = (hit_valid && int'(hit_idx) < NH) ? int'(hit_idx) : -1;
        if (tick) begin
            for (int i = 0; i < NH; i++) begin
                if (i == h && pre[i] == 1) continue;
                if (pre[i] == 1) begin
                    life[i]--;
                    if (life[i] <= 0) begin st[i] = 0; m_esc = 1; end
                end else if (pre[i] == 2) begin
                    wc[i]--;
                    if (wc[i] <= 0) st[i] = 0;
                end
            end
            if (up < MA) begin
                s = int'(lf % 16'd5);
                for (int k = 0; k < NH; k++) begin
                    if (pre[(s + k) % NH] == 0) begin
                        st[(s + k) % NH]   = 1;
                        life[(s + k) % NH] = (mole_life == 0) ? 1 : int'(mole_life);
                        break;
                    end
                end
            end
        end
        if (h >= 0) begin
            if (pre[h] == 1) begin
                st[h] = 2; wc[h] = WT; m_hit = 1;
`ifdef MOLE_FIELD_COMBO_EN
                m_score += (m_streak >= 4) ? 2 : 1;
`else
                m_score += 1;
`endif
                if (m_score > SMAX) m_score = SMAX;
            end else begin
                m_missp = 1;
                if (m_miss < SMAX) m_miss++;
            end
        end
`ifdef MOLE_FIELD_COMBO_EN
        if (m_missp || m_esc) m_streak = 0;
        else if (m_hit && m_streak < 255) m_streak++;
`endif
    endtask

    task automatic check_all(input string ph);
        logic [4:0] em, ew;
        for (int i = 0; i < NH; i++) begin em[i] = (st[i] == 1); ew[i] = (st[i] == 2); end
        check({ph, ".moles"},   moles, em);
        check({ph, ".whacked"}, whacked, ew);
        check({ph, ".score"},   score, m_score);
        check({ph, ".miss"},    miss_count, m_miss);
        check({ph, ".hitp"},    hit_pulse, m_hit);
        check({ph, ".missp"},   miss_pulse, m_missp);
        check({ph, ".escp"},    escape_pulse, m_esc);
        check({ph, ".streak"},  streak, m_streak);
    endtask

    task automatic cyc();
        @(posedge clock);
        if (!resetn) mreset(); else mstep();
        #1 check_all("cyc");
        @(negedge clock);
        tick = 1'b0; hit_valid = 1'b0; clear = 1'b0;
    endtask

    function automatic int first_with(input int v);
        for (int i = 0; i < NH; i++) if (st[i] == v) return i;
        return -1;
    endfunction

    task automatic async_reset(input string tag);
        resetn = 1'b0;
        #1 mreset();
        check_all(tag);
        cyc();
        resetn = 1'b1;
    endtask

    initial begin
        int j, found, hits, u;
        resetn = 1'b0; enable = 1'b1; clear = 1'b0; tick = 1'b0;
        hit_valid = 1'b0; hit_idx = '0; mole_life = 8'd10;
        mreset();
        cyc(); cyc();
        check("rst_moles", moles, 0);
        check("rst_score", score, 0);
        resetn = 1'b1;

        // Mid-game reset with two moles up.
        tick = 1'b1; cyc();
        tick = 1'b1; cyc();
        check("pre_rst_up", $countones(moles), 2);
        async_reset("midrst");
        check("midrst_moles", moles, 0);
        check("midrst_score", score, 0);
        repeat (3) begin
            cyc();
            check("post_rst_pulses", {hit_pulse, miss_pulse, escape_pulse}, 3'b000);
        end

        // Single mole lifetime of 3 ticks.
        clear = 1'b1; cyc();
        mole_life = 8'd3;
        tick = 1'b1; cyc();
        j = first_with(1);
        check("life_spawned", (j >= 0), 1);
        if (j < 0) j = 0;
        for (int t = 1; t <= 3; t++) begin
            tick = 1'b1; cyc();
            check("life_up", moles[j], (t < 3));
            check("life_esc", escape_pulse, (t == 3));
        end
        cyc();
        check("life_esc_once", escape_pulse, 0);

        // Hit on hole 2.
        clear = 1'b1; cyc();
        mole_life = 8'd10;
        found = 0;
        for (int n = 0; n < 200; n++) begin
            if (st[2] == 1) begin found = 1; break; end
            if (first_with(1) >= 0) clear = 1'b1; else tick = 1'b1;
            cyc();
        end
        check("h2_found", found, 1);
        hit_valid = 1'b1; hit_idx = 3'd2; cyc();
        check("h2_whacked", whacked[2], 1);
        check("h2_hitp", hit_pulse, 1);
        check("h2_score", score, 1);
        tick = 1'b1; cyc();
        check("h2_released", whacked[2], 0);

        // Miss on an empty hole, then an out-of-range index.
        clear = 1'b1; cyc();
        hit_valid = 1'b1; hit_idx = 3'd0; cyc();
        check("miss_cnt", miss_count, 1);
        check("miss_p", miss_pulse, 1);
        hit_valid = 1'b1; hit_idx = 3'd7; cyc();
        check("oor_cnt", miss_count, 1);
        check("oor_p", {hit_pulse, miss_pulse}, 2'b00);

        // Spawn cap.
        clear = 1'b1; cyc();
        repeat (3) begin tick = 1'b1; cyc(); end
        check("cap_pop", $countones(moles), 2);

        // Six consecutive hits, then a miss.
        clear = 1'b1; cyc();
        hits = 0;
        for (int n = 0; n < 100 && hits < 6; n++) begin
            u = first_with(1);
            if (u >= 0) begin hit_valid = 1'b1; hit_idx = 3'(u); hits++; end
            else tick = 1'b1;
            cyc();
        end
        check("streak_hits", hits, 6);
`ifdef MOLE_FIELD_COMBO_EN
        check("combo_score", score, 8);
        check("combo_streak", streak, 6);
`else
        check("plain_score", score, 6);
        check("plain_streak", streak, 0);
`endif
        u = first_with(0);
        hit_valid = 1'b1; hit_idx = 3'((u < 0) ? 0 : u); cyc();
        check("streak_miss", streak, 0);
        check("streak_miss_p", miss_pulse, 1);

        // Randomized play.
        for (int n = 0; n < 2000; n++) begin
            enable    = ($urandom_range(9) != 0);
            tick      = ($urandom_range(3) == 0);
            clear     = ($urandom_range(99) == 0);
            mole_life = 8'($urandom_range(5));
            hit_valid = ($urandom_range(2) == 0);
            u = first_with(1);
            if (u >= 0 && $urandom_range(1) == 0) hit_idx = 3'(u);
            else hit_idx = 3'($urandom_range(7));
            if ($urandom_range(299) == 0) async_reset("rnd_rst");
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
